csa_tree_pipe: RTL
==================

CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

Interface
REQ-001 Parameter DATA_W, default 3: width of each input operand; the allowed range is 1..32.
REQ-002 Parameter DATA_N, default 12: number of input operands; the allowed range is 2..64.
REQ-003 Parameter SIGNED, default 0: 0 treats operands as unsigned; 1 treats operands as two's complement.
REQ-004 Parameter ACC_W, default 16: accumulator width, used only under CSA_TREE_ACC_EN; it must be at least O_DATA_W.
REQ-005 Derived O_DATA_W = DATA_W + $clog2(DATA_N); STAGES_N = number of 3:2 levels needed to reduce DATA_N to 2 operands.
REQ-006 Port clk  input  1: the single clock; all state updates on the rising edge.
REQ-007 Port rst_n  input  1: synchronous, active-low reset.
REQ-008 Port i_valid  input  1: the input vector is valid this cycle.
REQ-009 Port i_ready  output  1: the block accepts the input vector this cycle.
REQ-010 Port i_data  input  [0:DATA_N-1][DATA_W-1:0]: operand vector.
REQ-011 Port o_valid  output  1: o_data holds a valid sum.
REQ-012 Port o_ready  input  1: the downstream consumer accepts o_data.
REQ-013 Port o_data  output  O_DATA_W: sum of all operands, sign-extended when SIGNED=1.
REQ-014 Port i_clear  input  1 (under CSA_TREE_ACC_EN only): restart accumulation with the current beat.
REQ-015 Port o_acc  output  ACC_W (under CSA_TREE_ACC_EN only): running accumulated total.

Function
REQ-016 Operands SHALL be zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to O_DATA_W before entering level 0.
REQ-017 Each level SHALL group operands in threes into 3:2 compressors, passing leftover operands (n%3) through registered and unchanged.
REQ-018 A level with n operands SHALL emit 2*floor(n/3)+n%3 operands; for example, DATA_N=12 gives 12->8->6->4->3->2, so STAGES_N=5.
REQ-019 Carry vectors SHALL be shifted left by 1 and truncated to O_DATA_W; this truncation is mod-2^O_DATA_W exact and gives no overflow for any legal input.
REQ-020 Every 3:2 level and the final carry-propagate add SHALL be registered, giving latency STAGES_N+1 cycles from accept to o_valid.
REQ-021 For DATA_N=2, STAGES_N is 0 and the latency SHALL be 1 cycle.
REQ-022 The pipeline SHALL use a global advance enable adv = ~o_valid | o_ready, and i_ready SHALL equal adv.
REQ-023 A per-stage valid bit SHALL travel with the data; when adv=0 all stage registers, valid bits and o_data SHALL hold.
REQ-024 While o_valid=1 and o_ready=0, o_data SHALL be stable.
REQ-025 An input with i_valid=1 and adv=0 SHALL NOT be captured; the upstream must hold it.
REQ-026 Bubbles (i_valid=0 while adv=1) SHALL propagate as invalid stages; data in invalid stages is don't-care.
REQ-027 Full throughput SHALL be one vector per cycle while o_ready stays 1.

Reset
REQ-028 On a clk edge with rst_n=0, all stage valid bits, o_valid, o_data and o_acc SHALL clear to 0.
REQ-029 i_ready SHALL read 1 during and immediately after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight vectors; no stale o_valid SHALL follow reset.

Configuration
REQ-031 Macro CSA_TREE_ACC_EN defined: on each o_valid&o_ready handshake, o_acc SHALL become (i_clear of that beat, carried in the valid pipeline) ? ext(o_data) : o_acc+ext(o_data).
REQ-032 With CSA_TREE_ACC_EN defined, ext() SHALL follow SIGNED and the sum SHALL wrap modulo 2^ACC_W.
REQ-033 Macro CSA_TREE_ACC_EN undefined: the i_clear and o_acc ports and all accumulator logic SHALL be absent.

Structure
REQ-034 Package csa_tree_pkg SHALL hold the constant functions stage_count(n), level_ops(n,level) and csa_count(n,level), used for generate sizing.
REQ-035 Sub-module csa_3to2, parametrised by width, SHALL be combinational (sum = a^b^c; carry = majority<<1); registering SHALL occur in csa_tree_pipe.

Verification
REQ-036 DATA_W=3, DATA_N=12, SIGNED=0, all operands 7, o_ready=1 -> o_data=84 with o_valid exactly 6 cycles after accept.
REQ-037 SIGNED=1, all operands 3'b111 -> o_data=-12 (7'b1110100); all operands 3'b100 -> o_data=-48.
REQ-038 Back-to-back vectors 1..10 with o_ready toggled 1,0,0,1 -> every sum is delivered in order with none lost or duplicated, o_data is stable while stalled, and i_ready=0 whenever o_valid=1&o_ready=0.
REQ-039 Reset asserted with 3 vectors in flight -> o_valid=0 on the next cycle and no output appears from the flushed vectors.
REQ-040 CSA_TREE_ACC_EN, sums 84,84,84 with i_clear on the first beat -> o_acc 84,168,252; i_clear on the fourth beat -> o_acc 84.
REQ-041 DATA_N=2 and DATA_N=3 (DATA_W=8, all 255) -> o_data 510 after 1 cycle and 765 after 2 cycles respectively.

Source files
------------

// File: rtl/csa_tree_pkg.sv
// Constant sizing helpers for the carry-save reduction tree in csa_tree_pipe.
// Each 3:2 level turns n operands into 2*floor(n/3) + n%3 operands.
package csa_tree_pkg;

    function automatic int level_ops(input int n, input int level);
        int ops;
        ops = n;
        for (int l = 0; l < level; l++) begin
            if (ops > 2) begin
                ops = 2 * (ops / 3) + ops % 3;
            end
        end
        return ops;
    endfunction

    function automatic int stage_count(input int n);
        int ops;
        int cnt;
        ops = n;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (ops > 2) begin
                ops = 2 * (ops / 3) + ops % 3;
                cnt++;
            end
        end
        return cnt;
    endfunction

    function automatic int csa_count(input int n, input int level);
        return level_ops(n, level) / 3;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Combinational 3:2 compressor: bitwise sum and majority carry shifted up one place.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);
    logic [W-1:0] maj;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // The top majority bit falls off; sums are taken modulo 2^W.
    assign carry_o = maj << 1;
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save adder tree summing DATA_N operands, one registered 3:2 level per stage.
// Defining CSA_TREE_ACC_EN adds i_clear/o_acc and a running accumulator on the output handshake.
module csa_tree_pipe
    import csa_tree_pkg::*;
#(
    parameter int  DATA_W   = 3,
    parameter int  DATA_N   = 12,
    parameter int  SIGNED   = 0,
    parameter int  ACC_W    = 16,
    localparam int O_DATA_W = DATA_W + $clog2(DATA_N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [0:DATA_N-1][DATA_W-1:0] i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [O_DATA_W-1:0]           o_data
`ifdef CSA_TREE_ACC_EN
    ,
    input  logic                          i_clear,
    output logic [ACC_W-1:0]              o_acc
`endif
);
    localparam int STAGES_N = stage_count(DATA_N);

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("csa_tree_pipe: DATA_W must be in 1..32");
    end
    if (DATA_N < 2 || DATA_N > 64) begin : g_bad_data_n
        $error("csa_tree_pipe: DATA_N must be in 2..64");
    end
    if (ACC_W < O_DATA_W) begin : g_bad_acc_w
        $error("csa_tree_pipe: ACC_W must be at least O_DATA_W");
    end

    logic                adv;
    logic                o_valid_q;
    logic [O_DATA_W-1:0] o_data_q;
    logic [O_DATA_W-1:0] o_data_d;
    logic [O_DATA_W-1:0] fin_a;
    logic [O_DATA_W-1:0] fin_b;
    logic                fin_vld;
    logic [O_DATA_W-1:0] in_ops [DATA_N];
`ifdef CSA_TREE_ACC_EN
    logic                fin_clr;
`endif

    // One global enable: the whole pipe freezes only when the output is full and blocked.
    assign adv     = ~o_valid_q | o_ready;
    assign i_ready = adv;

    for (genvar k = 0; k < DATA_N; k++) begin : g_ext
        if (SIGNED != 0) begin : g_sx
            assign in_ops[k] = O_DATA_W'(signed'(i_data[k]));
        end else begin : g_zx
            assign in_ops[k] = O_DATA_W'(i_data[k]);
        end
    end

    for (genvar l = 1; l <= STAGES_N; l++) begin : g_lvl
        localparam int N_P = level_ops(DATA_N, l - 1);
        localparam int N_L = level_ops(DATA_N, l);
        localparam int C_N = csa_count(DATA_N, l - 1);
        localparam int R_N = N_P - 3 * C_N;

        logic [O_DATA_W-1:0] prev  [N_P];
        logic                prev_vld;
        logic [O_DATA_W-1:0] ops_d [N_L];
        logic [O_DATA_W-1:0] ops_q [N_L];
        logic                vld_q;
`ifdef CSA_TREE_ACC_EN
        logic                prev_clr;
        logic                clr_q;
`endif

        if (l == 1) begin : g_first
            assign prev     = in_ops;
            assign prev_vld = i_valid;
`ifdef CSA_TREE_ACC_EN
            assign prev_clr = i_clear;
`endif
        end else begin : g_next
            assign prev     = g_lvl[l-1].ops_q;
            assign prev_vld = g_lvl[l-1].vld_q;
`ifdef CSA_TREE_ACC_EN
            assign prev_clr = g_lvl[l-1].clr_q;
`endif
        end

        for (genvar k = 0; k < C_N; k++) begin : g_csa
            csa_3to2 #(
                .W(O_DATA_W)
            ) u_csa (
                .a_i    (prev[3*k]),
                .b_i    (prev[3*k+1]),
                .c_i    (prev[3*k+2]),
                .sum_o  (ops_d[2*k]),
                .carry_o(ops_d[2*k+1])
            );
        end

        for (genvar k = 0; k < R_N; k++) begin : g_pass
            assign ops_d[2*C_N+k] = prev[3*C_N+k];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= prev_vld;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                ops_q <= ops_d;
`ifdef CSA_TREE_ACC_EN
                clr_q <= prev_clr;
`endif
            end
        end
    end

    if (STAGES_N == 0) begin : g_fin_in
        assign fin_a   = in_ops[0];
        assign fin_b   = in_ops[1];
        assign fin_vld = i_valid;
`ifdef CSA_TREE_ACC_EN
        assign fin_clr = i_clear;
`endif
    end else begin : g_fin_tree
        assign fin_a   = g_lvl[STAGES_N].ops_q[0];
        assign fin_b   = g_lvl[STAGES_N].ops_q[1];
        assign fin_vld = g_lvl[STAGES_N].vld_q;
`ifdef CSA_TREE_ACC_EN
        assign fin_clr = g_lvl[STAGES_N].clr_q;
`endif
    end

    assign o_data_d = fin_a + fin_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else if (adv) begin
            o_valid_q <= fin_vld;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

`ifdef CSA_TREE_ACC_EN
    logic             o_clr_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_ext;

    if (SIGNED != 0) begin : g_acc_sx
        assign sum_ext = ACC_W'(signed'(o_data_q));
    end else begin : g_acc_zx
        assign sum_ext = ACC_W'(o_data_q);
    end

    assign acc_d = o_clr_q ? sum_ext : acc_q + sum_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_clr_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            if (adv) begin
                o_clr_q <= fin_clr;
            end
            if (o_valid_q && o_ready) begin
                acc_q <= acc_d;
            end
        end
    end

    assign o_acc = acc_q;
`endif

endmodule
